ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_pkg.sv | 12 +
 rtl/ram_fifo_ctrl.sv | 99 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared defaults and output-FSM state encoding for the RAM-backed FIFO controller.
package ram_pkg;
   localparam int AW_DEF    = 4;
   localparam int DW_DEF    = 8;
   localparam int DEPTH_DEF = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FETCH = 2'd1,
      ST_VALID = 2'd2
   } outState_t;
endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external RAM with a combinational read port;
// the head word is staged in a registered output slot.
module ram_fifo_ctrl
   import ram_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          wrEn,
   output logic [AW-1:0] wrAddr,
   output logic [DW-1:0] wrData,
   output logic [AW-1:0] rdAddr,
   input  logic [DW-1:0] rdData,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty
);

   logic [AW-1:0] wrPtr;
   logic [AW-1:0] rdPtr;
   logic [AW:0]   memCount;
   outState_t     state;
   logic          push;
   logic          pop;
   logic          fetch;

   function automatic logic [AW-1:0] ptrInc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full      = (memCount == (AW+1)'(DEPTH));
   assign in_ready  = !full;
   // rst gates the write strobe so the RAM is never written while reset is held.
   assign push      = in_valid && in_ready && !rst;
   assign wrEn      = push;
   assign wrAddr    = wrPtr;
   assign wrData    = in_data;
   assign out_valid = (state == ST_VALID);
   assign pop       = out_valid && out_ready;
   assign fetch     = (memCount != '0) && ((state == ST_EMPTY) || pop);
   assign level     = memCount + (AW+1)'(state != ST_EMPTY);
   assign empty     = (level == '0);

   // Write side: pointer and count of words stored but not yet fetched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr    <= '0;
         memCount <= '0;
      end else begin
         if (push)
            wrPtr <= ptrInc(wrPtr);
         case ({push, fetch})
            2'b10:   memCount <= memCount + 1'b1;
            2'b01:   memCount <= memCount - 1'b1;
            default: memCount <= memCount;
         endcase
      end
   end

   // Read side: one cycle to present rdAddr to the RAM, then capture into out_data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_EMPTY;
         rdPtr    <= '0;
         rdAddr   <= '0;
         out_data <= '0;
      end else begin
         if (fetch) begin
            rdAddr <= rdPtr;
            rdPtr  <= ptrInc(rdPtr);
         end
         case (state)
            ST_EMPTY: begin
               if (fetch)
                  state <= ST_FETCH;
            end
            ST_FETCH: begin
               out_data <= rdData;
               state    <= ST_VALID;
            end
            ST_VALID: begin
               if (pop)
                  state <= fetch ? ST_FETCH : ST_EMPTY;
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: directed scenarios plus random traffic against a
// queue-based reference model, with a behavioural RAM beside the controller.
module tb_ram_fifo_ctrl;
   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          wrEn;
   logic [AW-1:0] wrAddr;
   logic [DW-1:0] wrData;
   logic [AW-1:0] rdAddr;
   logic [DW-1:0] rdData;
   logic [AW:0]   level;
   logic          full;
   logic          empty;

   logic [DW-1:0] ram [DEPTH];

   int checks = 0;
   int errors = 0;

   // Reference model: words stored in RAM, plus the output slot (loading or shown).
   logic [DW-1:0] ramQ[$];
   logic [DW-1:0] gotQ[$];
   int            popCyc[$];
   bit            slotHas;
   bit            slotShown;
   logic [DW-1:0] slotWord;
   int            wrCount;
   int            cyc;

   ram_fifo_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
      .rdAddr(rdAddr), .rdData(rdData),
      .level(level), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk)
      if (wrEn) ram[wrAddr] <= wrData;
   assign rdData = ram[rdAddr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic modelReset();
      ramQ.delete();
      slotHas   = 0;
      slotShown = 0;
      slotWord  = '0;
      wrCount   = 0;
   endtask

   task automatic checkOutputs();
      bit expReady;
      expReady = (ramQ.size() < DEPTH);
      chk("in_ready", in_ready, expReady);
      chk("full", full, !expReady);
      chk("wrEn", wrEn, in_valid && expReady);
      chk("wrAddr", wrAddr, wrCount % DEPTH);
      chk("wrData", wrData, in_data);
      chk("out_valid", out_valid, slotShown);
      if (slotShown) chk("out_data", out_data, slotWord);
      chk("level", level, ramQ.size() + (slotHas ? 1 : 0));
      chk("empty", empty, (ramQ.size() == 0) && !slotHas);
   endtask

   task automatic advanceModel();
      bit pushNow, popNow, fetchNow;
      pushNow  = in_valid && (ramQ.size() < DEPTH);
      popNow   = slotShown && out_ready;
      fetchNow = (ramQ.size() > 0) && (!slotHas || popNow);
      if (popNow) begin
         gotQ.push_back(slotWord);
         popCyc.push_back(cyc);
      end
      if (fetchNow) begin
         slotWord  = ramQ.pop_front();
         slotHas   = 1;
         slotShown = 0;
      end else if (popNow) begin
         slotHas   = 0;
         slotShown = 0;
      end else if (slotHas) begin
         slotShown = 1;
      end
      if (pushNow) begin
         ramQ.push_back(in_data);
         wrCount++;
      end
   endtask

   // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
   task automatic cycle();
      @(negedge clk);
      checkOutputs();
      advanceModel();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic doReset();
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hA5;
      #1;
      modelReset();
      chk("rst out_valid", out_valid, 0);
      chk("rst level", level, 0);
      chk("rst empty", empty, 1);
      chk("rst full", full, 0);
      chk("rst in_ready", in_ready, 1);
      chk("rst wrEn", wrEn, 0);
      chk("rst rdAddr", rdAddr, 0);
      chk("rst out_data", out_data, 0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      gotQ.delete();
      popCyc.delete();
   endtask

   task automatic waitValid(input string tag);
      int n = 0;
      while (!out_valid && n < 8) begin
         cycle();
         n++;
      end
      chk(tag, out_valid, 1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cyc = 0;
      modelReset();
      @(posedge clk);
      #1;

      // First word: write strobe in the push cycle, visible three cycles later.
      doReset();
      in_valid = 1'b1; in_data = 8'd25;
      #1;
      chk("push25 wrEn", wrEn, 1);
      chk("push25 wrAddr", wrAddr, 0);
      chk("push25 wrData", wrData, 25);
      cycle();
      in_valid = 1'b0;
      chk("lat +1 out_valid", out_valid, 0);
      cycle();
      chk("lat +2 out_valid", out_valid, 0);
      cycle();
      chk("lat +3 out_valid", out_valid, 1);
      chk("lat +3 out_data", out_data, 25);

      // Fill to full with the consumer stalled.
      doReset();
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_data = DW'(25 + i);
         cycle();
      end
      chk("16 pushes level", level, 16);
      chk("16 pushes in_ready", in_ready, 1);
      in_data = 8'd41;
      cycle();
      chk("17 pushes full", full, 1);
      chk("17 pushes in_ready", in_ready, 0);
      chk("17 pushes level", level, 17);
      in_data = 8'd99;
      cycle();
      in_valid = 1'b0;
      chk("full push ignored level", level, 17);

      // Drain at full rate.
      out_ready = 1'b1;
      for (int n = 0; n < 60 && !empty; n++) cycle();
      chk("drain empty", empty, 1);
      chk("drain count", gotQ.size(), 17);
      for (int i = 0; i < gotQ.size(); i++) begin
         chk("drain order", gotQ[i], 25 + i);
         if (i > 0) chk("drain spacing", popCyc[i] - popCyc[i-1], 2);
      end
      out_ready = 1'b0;

      // Simultaneous push and fetch issue with five words in RAM.
      doReset();
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_data = DW'(100 + i);
         cycle();
      end
      in_valid = 1'b0;
      waitValid("six words valid");
      chk("six words level", level, 6);
      in_valid = 1'b1; in_data = 8'd106; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("push+fetch level", level, 6);
      chk("push+fetch out_valid", out_valid, 0);

      // Asynchronous reset with data in flight.
      doReset();
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; in_data = DW'(60 + i);
         cycle();
      end
      in_valid = 1'b0;
      waitValid("seven words valid");
      chk("seven words level", level, 7);
      @(negedge clk);
      #1;
      in_valid = 1'b1;
      rst      = 1'b1;
      #1;
      chk("async rst out_valid", out_valid, 0);
      chk("async rst level", level, 0);
      chk("async rst wrEn", wrEn, 0);
      modelReset();
      @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0;
      gotQ.delete();
      popCyc.delete();

      // Random traffic: fill-biased, then balanced, then drain; exercises pointer wrap.
      for (int n = 0; n < 600; n++) begin
         in_valid  = ($urandom_range(0, 99) < ((n < 200) ? 85 : (n < 450) ? 50 : 0));
         out_ready = ($urandom_range(0, 99) < ((n < 200) ? 30 : (n < 450) ? 60 : 100));
         in_data   = DW'($urandom);
         cycle();
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("random drained empty", empty, 1);
      chk("random wrap seen", (wrCount >= 20), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
